alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Buffer stage directly downstream of the ALU. It captures every `m_axis_result_tdata`/`m_axis_result_tvalid` beat that the ALU produces. The ALU result port has no `tready` and cannot stall, so this block turns that stream into a backpressurable AXI-Stream master. It also raises an almost-full flag so the upstream controller can stop issuing operands before data is lost, and it records any beat dropped on overflow.

## Interface
- `DATA_WIDTH`, 64, result word width; matches the ALU.
- `DEPTH`, 16, FIFO entries; power of two, at least 4.
- `AFULL_MARGIN`, 2, `o_almost_full` asserts when `o_level >= DEPTH - AFULL_MARGIN`; range 1..DEPTH-1.
- `aclk`  in  1  single clock; all logic is rising-edge.
- `aresetn`  in  1  reset, synchronous and active-low.
- `s_axis_result_tdata`  in  DATA_WIDTH  ALU result word.
- `s_axis_result_tvalid`  in  1  ALU result strobe; there is no ready signal, so every asserted cycle is a write attempt.
- `m_axis_tdata`  out  DATA_WIDTH  head-of-FIFO word.
- `m_axis_tvalid`  out  1  FIFO non-empty.
- `m_axis_tready`  in  1  consumer accepts the head word.
- `o_level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `o_almost_full`  out  1  occupancy threshold flag.
- `o_overflow`  out  1  sticky flag: at least one beat dropped.
- `o_drop_count`  out  16  number of dropped beats, saturates at 16'hFFFF.
- `i_clear_status`  in  1  single-cycle pulse; clears `o_overflow` and `o_drop_count`.

## Operation
- Storage is a DEPTH-entry array with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits wide, plus an occupancy register `level`. Pointers wrap naturally from DEPTH-1 to 0. The storage array is not reset.
- Push condition: `s_axis_result_tvalid && (level < DEPTH || pop)`.
- Pop condition: `m_axis_tvalid && m_axis_tready`.
- `m_axis_tvalid = (level != 0)`.
- `m_axis_tdata = mem[rd_ptr]`. It holds stable while `tvalid && !tready`.
- Level update:
  - push only: `level + 1`.
  - pop only: `level - 1`.
  - both, or neither: unchanged.
- Full with a simultaneous pop: the push is accepted, because the popped slot frees space in the same cycle. No drop occurs.
- Drop condition: `s_axis_result_tvalid && level == DEPTH && !pop`. On a drop:
  - the word is discarded;
  - the pointers do not move;
  - `o_overflow` is set to 1;
  - `o_drop_count` increments, unless it is already at 16'hFFFF.
- `i_clear_status` in the same cycle as a drop: the drop wins. After that edge, `o_overflow = 1` and `o_drop_count = 1`.
- Empty with a push and `m_axis_tready = 1`: no same-cycle bypass. The word becomes visible on the next cycle.
- `o_almost_full` and `o_level` are derived from the registered `level` only.

## Timing
- Reset (`aresetn = 0` at a rising edge) forces:
  - `level = 0`, `wr_ptr = 0`, `rd_ptr = 0`;
  - `m_axis_tvalid = 0`, `o_almost_full = 0`, `o_overflow = 0`, `o_drop_count = 0`.
- `m_axis_tdata` is don't-care while `m_axis_tvalid = 0`.
- Reset mid-operation discards all stored words. Any push or pop in the reset cycle is ignored.
- Write-to-output latency: a word pushed at edge N appears on `m_axis_tdata` with `m_axis_tvalid = 1` after edge N (one cycle), provided it is at the head.
- Throughput is one push and one pop per cycle, sustained.
- Order is strictly FIFO.
- Status outputs update on the same edge as the event that changes them.

## Test plan
- Basic order: reset, then push 1, 2, 3 on consecutive cycles with `tready = 0`, then raise `tready`. Required: `m_axis_tdata` reads 1, 2, 3 on three consecutive cycles; `o_level` goes 3→2→1→0; `tvalid` deasserts after the third beat.
- Fill and overflow (DEPTH=16): 18 pushes with `tready = 0`. Required: `o_level = 16`, `o_overflow = 1`, `o_drop_count = 2`; pops return values 0..15 only.
- Full with simultaneous push and pop: at level 16, hold `tvalid` and `tready` for 5 cycles. Required: no drops, `o_level` stays 16, output order preserved.
- Almost-full threshold: with `AFULL_MARGIN = 2`, `o_almost_full` is 0 at level 13 and 1 at level 14. Popping back to 13 clears it.
- Clear racing a drop: with the FIFO full and `o_drop_count = 5`, assert `i_clear_status` together with a push and no pop. Required: `o_overflow = 1`, `o_drop_count = 1`. A clear alone on the next cycle gives 0 / 0.
- Reset mid-stream: at level 7 with pops in progress, assert `aresetn = 0` for one cycle. Required: `tvalid = 0` and `o_level = 0` next cycle. A new push then appears first at the output.

Source files
------------

// File: rtl/alu_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_result_fifo                                                          |
// | Buffers the stall-free ALU result stream into a backpressurable          |
// | AXI-Stream master, with almost-full and sticky overflow/drop status.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_result_fifo #(
   parameter int DATA_WIDTH   = 64,
   parameter int DEPTH        = 16,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [DATA_WIDTH-1:0]      s_axis_result_tdata,
   input  logic                       s_axis_result_tvalid,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_almost_full,
   output logic                       o_overflow,
   output logic [15:0]                o_drop_count,
   input  logic                       i_clear_status
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_LW = c_AW + 1;
   localparam logic [c_LW-1:0] c_FULL  = c_LW'(DEPTH);
   localparam logic [c_LW-1:0] c_AFULL = c_LW'(DEPTH - AFULL_MARGIN);
   localparam logic [15:0]     c_DMAX  = 16'hFFFF;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]       r_wr_ptr;
   logic [c_AW-1:0]       r_rd_ptr;
   logic [c_LW-1:0]       r_level;
   logic                  r_overflow;
   logic [15:0]           r_drop_count;

   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_full = (r_level == c_FULL);
   assign w_pop  = (r_level != '0) && m_axis_tready;
   // A pop frees its slot in the same cycle, so a full FIFO can still accept.
   assign w_push = s_axis_result_tvalid && (!w_full || w_pop);
   assign w_drop = s_axis_result_tvalid && w_full && !w_pop;

   // Storage is intentionally left unreset; reset-cycle writes are suppressed.
   always_ff @(posedge aclk) begin
      if (aresetn && w_push) begin
         r_mem[r_wr_ptr] <= s_axis_result_tdata;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LW'(1);
            2'b01:   r_level <= r_level - c_LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // A drop in the same cycle as a clear wins and restarts the count at one.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (i_clear_status) begin
            r_drop_count <= 16'd1;
         end else if (r_drop_count != c_DMAX) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end else if (i_clear_status) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end
   end

   assign m_axis_tdata  = r_mem[r_rd_ptr];
   assign m_axis_tvalid = (r_level != '0);
   assign o_level       = r_level;
   assign o_almost_full = (r_level >= c_AFULL);
   assign o_overflow    = r_overflow;
   assign o_drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_result_fifo                                                       |
// | Directed vector table plus hand-written multi-cycle corner sequences.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_result_fifo;

   localparam int DW = 64;
   localparam int DEPTH = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [4:0]    level;
   logic          afull;
   logic          ovf;
   logic [15:0]   drops;
   logic          clr = 1'b0;

   int total = 0;
   int bad = 0;

   alu_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_MARGIN(2)) dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .s_axis_result_tdata  (s_data),
      .s_axis_result_tvalid (s_valid),
      .m_axis_tdata         (m_data),
      .m_axis_tvalid        (m_valid),
      .m_axis_tready        (m_ready),
      .o_level              (level),
      .o_almost_full        (afull),
      .o_overflow           (ovf),
      .o_drop_count         (drops),
      .i_clear_status       (clr)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          rdy;
      logic          clr;
      logic          et;
      logic [DW-1:0] ed;
      logic [4:0]    el;
      logic          ea;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      clr     = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic push_n(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(base + i);
         tick();
      end
      s_valid = 1'b0;
   endtask

   initial begin
      int exp_head;

      do_reset();
      chk("rst_tvalid", DW'(m_valid), 0);
      chk("rst_level", DW'(level), 0);
      chk("rst_afull", DW'(afull), 0);
      chk("rst_ovf", DW'(ovf), 0);
      chk("rst_drops", DW'(drops), 0);

      // Basic order, then empty-with-push-and-ready (no bypass) and steady flow.
      vecs[0] = '{1'b1, 64'h1,  1'b0, 1'b0, 1'b1, 64'h1,  5'd1, 1'b0};
      vecs[1] = '{1'b1, 64'h2,  1'b0, 1'b0, 1'b1, 64'h1,  5'd2, 1'b0};
      vecs[2] = '{1'b1, 64'h3,  1'b0, 1'b0, 1'b1, 64'h1,  5'd3, 1'b0};
      vecs[3] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h2,  5'd2, 1'b0};
      vecs[4] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h3,  5'd1, 1'b0};
      vecs[5] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 64'h0,  5'd0, 1'b0};
      vecs[6] = '{1'b1, 64'hAA, 1'b1, 1'b0, 1'b1, 64'hAA, 5'd1, 1'b0};
      vecs[7] = '{1'b1, 64'hBB, 1'b1, 1'b0, 1'b1, 64'hBB, 5'd1, 1'b0};
      vecs[8] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 64'h0,  5'd0, 1'b0};

      for (int i = 0; i < 9; i++) begin
         s_valid = vecs[i].v;
         s_data  = vecs[i].d;
         m_ready = vecs[i].rdy;
         clr     = vecs[i].clr;
         tick();
         chk($sformatf("vec%0d_tvalid", i), DW'(m_valid), DW'(vecs[i].et));
         chk($sformatf("vec%0d_level", i), DW'(level), DW'(vecs[i].el));
         chk($sformatf("vec%0d_afull", i), DW'(afull), DW'(vecs[i].ea));
         if (vecs[i].et) chk($sformatf("vec%0d_tdata", i), m_data, vecs[i].ed);
      end
      s_valid = 1'b0;
      m_ready = 1'b0;

      // Fill and overflow: 18 pushes into 16 entries.
      do_reset();
      push_n(18, 0);
      chk("fill_level", DW'(level), 16);
      chk("fill_ovf", DW'(ovf), 1);
      chk("fill_drops", DW'(drops), 2);
      chk("fill_afull", DW'(afull), 1);
      chk("fill_head", m_data, 0);

      // Full with simultaneous push and pop for 5 cycles.
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_data  = DW'(100 + k);
         m_ready = 1'b1;
         tick();
         chk($sformatf("fullpp%0d_level", k), DW'(level), 16);
         chk($sformatf("fullpp%0d_head", k), m_data, DW'(k + 1));
         chk($sformatf("fullpp%0d_drops", k), DW'(drops), 2);
      end
      s_valid = 1'b0;

      // Drain: 5..15 followed by 100..104.
      for (int k = 0; k < 16; k++) begin
         exp_head = (k < 11) ? (k + 5) : (100 + k - 11);
         chk($sformatf("drain%0d_tvalid", k), DW'(m_valid), 1);
         chk($sformatf("drain%0d_tdata", k), m_data, DW'(exp_head));
         tick();
      end
      chk("drain_level", DW'(level), 0);
      chk("drain_tvalid", DW'(m_valid), 0);
      m_ready = 1'b0;

      // Almost-full threshold at DEPTH - 2.
      do_reset();
      push_n(13, 0);
      chk("af13_level", DW'(level), 13);
      chk("af13_afull", DW'(afull), 0);
      push_n(1, 13);
      chk("af14_level", DW'(level), 14);
      chk("af14_afull", DW'(afull), 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("afpop_level", DW'(level), 13);
      chk("afpop_afull", DW'(afull), 0);

      // Clear racing a drop.
      do_reset();
      push_n(21, 0);
      chk("race_pre_drops", DW'(drops), 5);
      s_valid = 1'b1;
      s_data  = 64'hDEAD;
      clr     = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("race_ovf", DW'(ovf), 1);
      chk("race_drops", DW'(drops), 1);
      chk("race_level", DW'(level), 16);
      tick();
      clr = 1'b0;
      chk("clr_ovf", DW'(ovf), 0);
      chk("clr_drops", DW'(drops), 0);
      chk("clr_head", m_data, 0);

      // Reset mid-stream.
      do_reset();
      push_n(7, 50);
      m_ready = 1'b1;
      tick();
      tick();
      chk("mid_level", DW'(level), 5);
      chk("mid_head", m_data, 52);
      aresetn = 1'b0;
      s_valid = 1'b1;
      s_data  = 64'h99;
      tick();
      chk("midrst_tvalid", DW'(m_valid), 0);
      chk("midrst_level", DW'(level), 0);
      aresetn = 1'b1;
      m_ready = 1'b0;
      s_data  = 64'h77;
      tick();
      s_valid = 1'b0;
      chk("postrst_tvalid", DW'(m_valid), 1);
      chk("postrst_level", DW'(level), 1);
      chk("postrst_tdata", m_data, 64'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
